free_list: RTL and testbench
============================

// Module: free_list
// PURPOSE
// - Physical-register free list; consumer of the ROB retire port, producer of rename destinations.
// - Each cycle hands up to 3 free physical tags (x,y,z) to rename/issue.
// - Each cycle accepts up to 3 released old tags (Pw_retire_*) back from ROB retirement.
// - On flush, rewinds the allocation pointer to the last committed point. This reclaims every tag handed out to squashed ops.
// PARAMETERS
// - NUM_PREG  32  physical registers; power of two; tag width = $clog2(NUM_PREG) = 5
// - NUM_AREG  8   architectural registers; P0..P(NUM_AREG-1) are mapped at reset, never on the list at reset
// PORTS
// - clk           in   1  clock
// - rst           in   1  reset, synchronous, active-high
// - flush         in   1  squash all uncommitted allocations (from ROB exception retire)
// - freeze_front  in   1  front end stalled; no allocation this cycle
// - full_FL       out  1  fewer than 3 free tags available; front end must stall
// - valid_alloc_x/y/z   in   1  slot needs a destination tag this cycle
// - Pw_x/y/z      out  5  allocated tag per slot; meaningful only when that slot's valid_alloc is 1
// - RegWr_x/y/z   in   1  retiring op in slot writes a register (from ROB)
// - exp_x/y/z     in   1  retiring op in slot raised an exception (from ROB)
// - Pw_retire_x/y/z  in   5  old tag being released by the retiring op
// BEHAVIOUR
// - Storage and pointers
//   - Circular array fl[NUM_PREG] of 5-bit tags.
//   - Pointers head, commit_head, tail: 6-bit each (MSB = wrap bit).
//   - avail = tail - head (6-bit modular). full_FL = (avail < 3), decoded from flops only; no dependence on valid_alloc_*.
// - Reset
//   - fl[i] = NUM_AREG + i for i < NUM_PREG-NUM_AREG; other entries 0.
//   - head = commit_head = 0; tail = NUM_PREG-NUM_AREG (24); full_FL = 0.
//   - Pw_* are combinational; after reset they read fl[0..2] = 8,9,10.
// - Allocation (same-cycle, combinational read)
//   - a_x, a_y, a_z = valid_alloc_* & ~freeze_front & ~full_FL & ~flush.
//   - Requests are compacted in x,y,z order:
//     - Pw_x = fl[head]
//     - Pw_y = fl[head + a_x]
//     - Pw_z = fl[head + a_x + a_y]
//   - Next edge: head += a_x + a_y + a_z. Indices wrap modulo NUM_PREG.
//   - All-or-nothing: full_FL guarantees 3 tags, so no partial grants.
// - Release (registered, one cycle)
//   - f_k = RegWr_k & ~exp_k.
//   - Valid frees are compacted at tail in x,y,z order.
//   - Next edge: tail += f_x + f_y + f_z.
//   - commit_head += the same count; each retiring register-writer makes one allocation permanent.
// - Flush
//   - Next edge: head = commit_head_next (commit_head plus this cycle's frees).
//   - Allocation is suppressed in the flush cycle.
//   - Frees arriving in the flush cycle are written normally.
//   - Tags between old commit_head and head become free again; no tag is lost or duplicated.
// - Simultaneous events
//   - Alloc and free in the same cycle update head and tail independently.
//   - A tag freed this cycle is not allocatable until the next cycle, because avail comes from flops.
// - Invariants (assert in sim)
//   - avail <= NUM_PREG-NUM_AREG.
//   - commit_head never passes head, tail never passes commit_head + NUM_PREG.
//   - Never free while avail == NUM_PREG-NUM_AREG.
// - Reset mid-operation: every pointer and array entry returns to its reset value; in-flight frees are dropped.
// STRUCTURE
// - Shared package: NUM_PREG, NUM_AREG, preg_t (5-bit tag), fl_ptr_t (6-bit pointer).
// - Shared package: function popcnt3() returning 0..3; also reused by ROB.
// - No sub-module; one always_ff for array and pointers, one always_comb for compaction and Pw_* read.
// TESTING
// - Reset, 3 allocs per cycle ->
//   - cycle 0 gives Pw 8,9,10; next cycle 11,12,13.
//   - After 8 cycles (24 tags) full_FL = 1 and head == tail.
// - valid_alloc = {x:1, y:0, z:1} -> Pw_x = 8, Pw_z = 9, head += 2; Pw_y is don't-care.
// - freeze_front = 1 with all valids -> head unchanged, same Pw values held next cycle.
// - Alloc 8,9,10, then retire RegWr = 111 with Pw_retire 1,2,3 ->
//   - fl[24..26] = 1,2,3, tail = 27, commit_head = 3.
// - Alloc 6 tags (8..13), retire 2 with RegWr, then flush ->
//   - head = commit_head = 2; next allocs give 10,11,12.
// - Same cycle: exp_x = 1, RegWr_x = 1, flush = 1 -> slot x not freed, tail unchanged, head = commit_head.
// - Wrap-around: run 100 random alloc/free/flush cycles -> tag multiset conserved.
//   - Every tag 0..31 appears exactly once among: mapped, on-list, or in-flight.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared types and helpers for the physical-register free list and its neighbours
// (rename, ROB). Tags are physical register numbers; pointers carry one extra
// wrap bit so that "empty" and "full" occupancy can be told apart.
package free_list_pkg;

  localparam int NUM_PREG = 32;
  localparam int NUM_AREG = 8;
  localparam int TAG_W    = $clog2(NUM_PREG);
  localparam int PTR_W    = TAG_W + 1;
  localparam int NUM_FREE = NUM_PREG - NUM_AREG;

  typedef logic [TAG_W-1:0] preg_t;
  typedef logic [PTR_W-1:0] fl_ptr_t;

  // Pointer-width constants, so comparisons never mix widths.
  localparam fl_ptr_t FREE_PTR  = fl_ptr_t'(NUM_FREE);
  localparam fl_ptr_t PREG_PTR  = fl_ptr_t'(NUM_PREG);
  localparam fl_ptr_t MIN_AVAIL = fl_ptr_t'(3);

  // Number of set bits among three slot flags (0..3).
  function automatic logic [1:0] popcnt3(input logic a, input logic b, input logic c);
    popcnt3 = {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

  // Zero-extend a 0..3 slot count to pointer width.
  function automatic fl_ptr_t cnt_to_ptr(input logic [1:0] cnt);
    cnt_to_ptr = {{(PTR_W-2){1'b0}}, cnt};
  endfunction

  // Zero-extend a single slot flag to tag (array index) width.
  function automatic preg_t bit_to_idx(input logic b);
    bit_to_idx = {{(TAG_W-1){1'b0}}, b};
  endfunction

endpackage

// File: rtl/free_list_chk.sv
// Simulation-only invariant checker for the free list pointers. Holds no
// functional state; it only watches the pointers and the release count.
module free_list_chk
  import free_list_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PTR_W-1:0]    head_i,
  input  logic [PTR_W-1:0]    commit_head_i,
  input  logic [PTR_W-1:0]    tail_i,
  input  logic [1:0]          free_cnt_i
);

  fl_ptr_t avail_s;
  fl_ptr_t spec_s;
  fl_ptr_t span_s;

  // Modular distances between the three pointers.
  always_comb begin
    avail_s = tail_i - head_i;
    spec_s  = head_i - commit_head_i;
    span_s  = tail_i - commit_head_i;
  end

  // Occupancy and pointer-ordering invariants, checked outside reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (avail_s <= FREE_PTR);
      assert (spec_s <= FREE_PTR);
      assert (span_s <= PREG_PTR);
      assert (!((avail_s == FREE_PTR) && (free_cnt_i != 2'd0)));
    end
  end

endmodule

// File: rtl/free_list.sv
// Physical-register free list. Hands out up to three free tags per cycle to
// rename (combinational read at head) and takes back up to three released tags
// per cycle from ROB retirement (written at tail on the next edge). A separate
// commit_head tracks how far allocation has become permanent so a flush can
// rewind head and reclaim every tag given to squashed ops.
module free_list
  import free_list_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             freeze_front_i,
  output logic             full_FL_o,
  input  logic             valid_alloc_x_i,
  input  logic             valid_alloc_y_i,
  input  logic             valid_alloc_z_i,
  output logic [TAG_W-1:0] Pw_x_o,
  output logic [TAG_W-1:0] Pw_y_o,
  output logic [TAG_W-1:0] Pw_z_o,
  input  logic             RegWr_x_i,
  input  logic             RegWr_y_i,
  input  logic             RegWr_z_i,
  input  logic             exp_x_i,
  input  logic             exp_y_i,
  input  logic             exp_z_i,
  input  logic [TAG_W-1:0] Pw_retire_x_i,
  input  logic [TAG_W-1:0] Pw_retire_y_i,
  input  logic [TAG_W-1:0] Pw_retire_z_i
);

  preg_t   fl_q [NUM_PREG];
  fl_ptr_t head_q;
  fl_ptr_t head_d;
  fl_ptr_t commit_head_q;
  fl_ptr_t commit_head_d;
  fl_ptr_t tail_q;
  fl_ptr_t tail_d;

  fl_ptr_t    avail_s;
  logic       full_s;
  logic       a_x_s;
  logic       a_y_s;
  logic       a_z_s;
  logic       f_x_s;
  logic       f_y_s;
  logic       f_z_s;
  logic [1:0] alloc_cnt_s;
  logic [1:0] free_cnt_s;
  preg_t      rd_idx_x_s;
  preg_t      rd_idx_y_s;
  preg_t      rd_idx_z_s;
  preg_t      wr_idx_x_s;
  preg_t      wr_idx_y_s;
  preg_t      wr_idx_z_s;

  // Occupancy, request/release compaction, tag read-out and next pointers.
  always_comb begin
    // Occupancy comes from flops only, so full never depends on this cycle's requests.
    avail_s = tail_q - head_q;
    full_s  = (avail_s < MIN_AVAIL);

    // Grants: all-or-nothing because full_s guarantees three tags are present.
    a_x_s = valid_alloc_x_i & ~freeze_front_i & ~full_s & ~flush_i;
    a_y_s = valid_alloc_y_i & ~freeze_front_i & ~full_s & ~flush_i;
    a_z_s = valid_alloc_z_i & ~freeze_front_i & ~full_s & ~flush_i;
    alloc_cnt_s = popcnt3(a_x_s, a_y_s, a_z_s);

    // Requesting slots take consecutive entries from head in x,y,z order.
    rd_idx_x_s = head_q[TAG_W-1:0];
    rd_idx_y_s = rd_idx_x_s + bit_to_idx(a_x_s);
    rd_idx_z_s = rd_idx_y_s + bit_to_idx(a_y_s);
    Pw_x_o = fl_q[rd_idx_x_s];
    Pw_y_o = fl_q[rd_idx_y_s];
    Pw_z_o = fl_q[rd_idx_z_s];

    // A retiring op returns its old tag only if it wrote a register and did not fault.
    f_x_s = RegWr_x_i & ~exp_x_i;
    f_y_s = RegWr_y_i & ~exp_y_i;
    f_z_s = RegWr_z_i & ~exp_z_i;
    free_cnt_s = popcnt3(f_x_s, f_y_s, f_z_s);

    // Released tags are packed at tail in x,y,z order.
    wr_idx_x_s = tail_q[TAG_W-1:0];
    wr_idx_y_s = wr_idx_x_s + bit_to_idx(f_x_s);
    wr_idx_z_s = wr_idx_y_s + bit_to_idx(f_y_s);

    // Each retiring register-writer makes one earlier allocation permanent.
    tail_d        = tail_q + cnt_to_ptr(free_cnt_s);
    commit_head_d = commit_head_q + cnt_to_ptr(free_cnt_s);

    // A flush rewinds head to the committed point, including this cycle's commits.
    if (flush_i) begin
      head_d = commit_head_d;
    end else begin
      head_d = head_q + cnt_to_ptr(alloc_cnt_s);
    end
  end

  assign full_FL_o = full_s;

  // Tag array and pointers; reset restores the initial free pool and drops in-flight frees.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_PREG; i++) begin
        fl_q[i] <= (i < NUM_FREE) ? preg_t'(NUM_AREG + i) : {TAG_W{1'b0}};
      end
      head_q        <= {PTR_W{1'b0}};
      commit_head_q <= {PTR_W{1'b0}};
      tail_q        <= FREE_PTR;
    end else begin
      if (f_x_s) begin
        fl_q[wr_idx_x_s] <= Pw_retire_x_i;
      end
      if (f_y_s) begin
        fl_q[wr_idx_y_s] <= Pw_retire_y_i;
      end
      if (f_z_s) begin
        fl_q[wr_idx_z_s] <= Pw_retire_z_i;
      end
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
    end
  end

  free_list_chk u_chk (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .head_i        (head_q),
    .commit_head_i (commit_head_q),
    .tail_i        (tail_q),
    .free_cnt_i    (free_cnt_s)
  );

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios plus randomized rename/retire/flush
// traffic. The reference model is a free-tag queue, a speculative and a
// committed rename map and an in-order ROB of {old tag, new tag, arch reg}.
// Expected outputs are queued by the stimulus and compared by a monitor.
module tb_free_list;
  import free_list_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, freeze, full;
  logic       va_x, va_y, va_z;
  logic [4:0] pw_x, pw_y, pw_z;
  logic       rw_x, rw_y, rw_z, ex_x, ex_y, ex_z;
  logic [4:0] pr_x, pr_y, pr_z;

  free_list dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .freeze_front_i(freeze),
    .full_FL_o(full),
    .valid_alloc_x_i(va_x), .valid_alloc_y_i(va_y), .valid_alloc_z_i(va_z),
    .Pw_x_o(pw_x), .Pw_y_o(pw_y), .Pw_z_o(pw_z),
    .RegWr_x_i(rw_x), .RegWr_y_i(rw_y), .RegWr_z_i(rw_z),
    .exp_x_i(ex_x), .exp_y_i(ex_y), .exp_z_i(ex_z),
    .Pw_retire_x_i(pr_x), .Pw_retire_y_i(pr_y), .Pw_retire_z_i(pr_z)
  );

  typedef struct packed {
    logic [2:0] g;
    logic       full;
    logic [4:0] p0;
    logic [4:0] p1;
    logic [4:0] p2;
  } exp_t;

  typedef struct {
    int old_t;
    int new_t;
    int areg;
  } op_t;

  exp_t exp_q[$];
  exp_t mon_e;
  op_t  rob[$];
  int   fl_m[$];
  int   smap[8];
  int   cmap[8];
  int   tests = 0;
  int   errors = 0;
  bit   collect = 1'b0;
  int   drained[$];

  function automatic void chk(string name, int act, int expv);
    tests++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endfunction

  // Monitor: compare the DUT against the oldest queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("full_FL", int'(full), int'(mon_e.full));
      if (mon_e.g[0]) chk("Pw_x", int'(pw_x), int'(mon_e.p0));
      if (mon_e.g[1]) chk("Pw_y", int'(pw_y), int'(mon_e.p1));
      if (mon_e.g[2]) chk("Pw_z", int'(pw_z), int'(mon_e.p2));
      if (collect) begin
        if (mon_e.g[0]) drained.push_back(int'(pw_x));
        if (mon_e.g[1]) drained.push_back(int'(pw_y));
        if (mon_e.g[2]) drained.push_back(int'(pw_z));
      end
    end
  end

  task automatic model_reset();
    fl_m.delete();
    rob.delete();
    for (int i = NUM_AREG; i < NUM_PREG; i++) fl_m.push_back(i);
    for (int i = 0; i < NUM_AREG; i++) begin
      smap[i] = i;
      cmap[i] = i;
    end
  endtask

  // Reset with junk retire traffic present; the frees must be dropped.
  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    {va_x, va_y, va_z} = 3'($urandom);
    {rw_x, rw_y, rw_z} = 3'b111;
    {ex_x, ex_y, ex_z} = 3'b000;
    pr_x = 5'($urandom); pr_y = 5'($urandom); pr_z = 5'($urandom);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle: drive inputs, queue the expected response, advance the model.
  // Slots with rw set retire the oldest ROB ops in order; ex may only mark the
  // last retiring slot and always comes with a flush.
  task automatic do_cycle(input logic [2:0] va, input logic frz, input logic fls,
                          input logic [2:0] rw, input logic [2:0] ex,
                          input int d0, input int d1, input int d2);
    exp_t e;
    op_t  op;
    int   k, idx, ncommit;
    int   dst[3];
    int   tagv[3];
    int   freed[$];
    logic [4:0] rt[3];
    dst[0] = (d0 < 0) ? $urandom_range(0, 7) : d0;
    dst[1] = (d1 < 0) ? $urandom_range(0, 7) : d1;
    dst[2] = (d2 < 0) ? $urandom_range(0, 7) : d2;
    e.full = (fl_m.size() < 3);
    e.g = va & {3{~frz & ~e.full & ~fls}};
    k = 0;
    for (int s = 0; s < 3; s++) begin
      tagv[s] = 0;
      if (e.g[s]) begin
        tagv[s] = fl_m[k];
        k++;
      end
    end
    e.p0 = 5'(tagv[0]); e.p1 = 5'(tagv[1]); e.p2 = 5'(tagv[2]);
    idx = 0; ncommit = 0;
    for (int s = 0; s < 3; s++) begin
      if (rw[s]) begin
        rt[s] = 5'(rob[idx].old_t);
        if (!ex[s]) ncommit++;
        idx++;
      end else begin
        rt[s] = 5'($urandom_range(0, 31));
      end
    end
    {va_z, va_y, va_x} = va;
    {rw_z, rw_y, rw_x} = rw;
    {ex_z, ex_y, ex_x} = ex;
    pr_x = rt[0]; pr_y = rt[1]; pr_z = rt[2];
    freeze = frz; flush = fls;
    exp_q.push_back(e);
    for (int i = 0; i < ncommit; i++) begin
      op = rob.pop_front();
      cmap[op.areg] = op.new_t;
      freed.push_back(op.old_t);
    end
    for (int s = 0; s < 3; s++) begin
      if (e.g[s]) begin
        op.new_t = fl_m.pop_front();
        op.areg  = dst[s];
        op.old_t = smap[dst[s]];
        smap[dst[s]] = op.new_t;
        rob.push_back(op);
      end
    end
    if (fls) begin
      while (rob.size() > 0) begin
        op = rob.pop_back();
        fl_m.push_front(op.new_t);
      end
      smap = cmap;
    end
    foreach (freed[i]) fl_m.push_back(freed[i]);
    @(posedge clk); #1;
  endtask

  function automatic logic [2:0] pick_mask(input int n);
    logic [2:0] m;
    m = 3'b000;
    while ($countones(m) < n) m[$urandom_range(0, 2)] = 1'b1;
    return m;
  endfunction

  task automatic rand_cycle();
    logic [2:0] va, rw, ex;
    logic frz, fls;
    int n;
    bit done;
    va  = 3'($urandom);
    frz = ($urandom_range(0, 7) == 0);
    fls = ($urandom_range(0, 15) == 0);
    n = $urandom_range(0, 3);
    if (n > rob.size()) n = rob.size();
    rw = pick_mask(n);
    ex = 3'b000;
    done = 1'b0;
    if (fls && n > 0 && $urandom_range(0, 1) == 1) begin
      for (int s = 2; s >= 0; s--) begin
        if (!done && rw[s]) begin
          ex[s] = 1'b1;
          done = 1'b1;
        end
      end
    end
    do_cycle(va, frz, fls, rw, ex, -1, -1, -1);
  endtask

  int cnt[32];
  int bad;
  int n;

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    {va_x, va_y, va_z} = 3'b000;
    {rw_x, rw_y, rw_z} = 3'b000;
    {ex_x, ex_y, ex_z} = 3'b000;
    pr_x = 5'd0; pr_y = 5'd0; pr_z = 5'd0;
    repeat (2) @(posedge clk);
    #1;

    // Full-rate allocation drains 24 tags in 8 cycles, then full.
    do_reset();
    repeat (9) do_cycle(3'b111, 1'b0, 1'b0, 3'b000, 3'b000, -1, -1, -1);

    // Sparse request: x and z take consecutive tags.
    do_reset();
    do_cycle(3'b101, 1'b0, 1'b0, 3'b000, 3'b000, -1, -1, -1);
    do_cycle(3'b111, 1'b0, 1'b0, 3'b000, 3'b000, -1, -1, -1);

    // Frozen front end allocates nothing.
    do_reset();
    repeat (2) do_cycle(3'b111, 1'b1, 1'b0, 3'b000, 3'b000, -1, -1, -1);
    do_cycle(3'b111, 1'b0, 1'b0, 3'b000, 3'b000, -1, -1, -1);

    // Retire releasing tags 1,2,3; they reappear after the initial pool.
    do_reset();
    do_cycle(3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1, 2, 3);
    do_cycle(3'b000, 1'b0, 1'b0, 3'b111, 3'b000, -1, -1, -1);
    repeat (9) do_cycle(3'b111, 1'b0, 1'b0, 3'b000, 3'b000, -1, -1, -1);

    // Six allocs, two retire, flush: allocation resumes at tag 10.
    do_reset();
    repeat (2) do_cycle(3'b111, 1'b0, 1'b0, 3'b000, 3'b000, -1, -1, -1);
    do_cycle(3'b000, 1'b0, 1'b0, 3'b011, 3'b000, -1, -1, -1);
    do_cycle(3'b111, 1'b0, 1'b1, 3'b000, 3'b000, -1, -1, -1);
    do_cycle(3'b111, 1'b0, 1'b0, 3'b000, 3'b000, -1, -1, -1);

    // Faulting retire with flush: nothing freed, everything reclaimed.
    do_reset();
    do_cycle(3'b111, 1'b0, 1'b0, 3'b000, 3'b000, -1, -1, -1);
    do_cycle(3'b111, 1'b0, 1'b1, 3'b001, 3'b001, -1, -1, -1);
    do_cycle(3'b111, 1'b0, 1'b0, 3'b000, 3'b000, -1, -1, -1);

    // Random traffic with a reset in the middle.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      else rand_cycle();
    end

    // Retire everything, then pull the whole pool out of the DUT.
    while (rob.size() > 0) begin
      n = (rob.size() > 3) ? 3 : rob.size();
      do_cycle(3'b000, 1'b0, 1'b0, pick_mask(n), 3'b000, -1, -1, -1);
    end
    collect = 1'b1;
    repeat (9) do_cycle(3'b111, 1'b0, 1'b0, 3'b000, 3'b000, -1, -1, -1);
    do_cycle(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, -1, -1, -1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);
    collect = 1'b0;

    // Every tag is either mapped or came back out of the free list exactly once.
    for (int i = 0; i < 32; i++) cnt[i] = 0;
    foreach (drained[i]) cnt[drained[i]]++;
    for (int i = 0; i < NUM_AREG; i++) cnt[cmap[i]]++;
    bad = 0;
    for (int i = 0; i < 32; i++) if (cnt[i] != 1) bad++;
    chk("drained_count", drained.size(), NUM_FREE);
    chk("tag_conservation", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
